// File: rtl/led_serial_tx_pkg.sv
// Shared constants for the KEY-driven serial blocks: FSM state encoding and
// line levels of the start/data/stop frame (also used by the serial receiver).
package led_serial_tx_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer for a raw KEY level plus a one-cycle pulse on the
// rising edge of the synchronized level.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic push
);

  logic r;
  logic rr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r  <= 1'b0;
      rr <= 1'b0;
    end else begin
      r  <= button;
      rr <= r;
    end
  end

  assign push = r & ~rr;

endmodule

// File: rtl/led_serial_tx.sv
// Button-triggered parallel-in serial-out transmitter: captures data_in on a
// KEY press and sends start bit, DATA_W data bits and stop bit on tx_out.
module led_serial_tx
  import led_serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_TICKS = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_button,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] shift_view
);

  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  logic [1:0]        state;
  logic [TW-1:0]     tick;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              order;
  logic              push;
  logic              tick_end;

  button_edge u_button_edge (
    .clk    (clk),
    .reset  (reset),
    .button (send_button),
    .push   (push)
  );

  assign tick_end   = (tick == TICK_LAST);
  assign shift_view = shreg;

  // tx_out is registered from the current state, so the line trails the
  // state register by one cycle; every bit still lasts BIT_TICKS cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      order   <= 1'b0;
      tx_out  <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_out <= IDLE_LEVEL;
          if (push) begin
            shreg   <= data_in;
            order   <= lsb_first;
            bit_cnt <= '0;
            tick    <= '0;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          tx_out <= START_LEVEL;
          if (tick_end) begin
            tick  <= '0;
            state <= S_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_DATA: begin
          tx_out <= order ? shreg[0] : shreg[DATA_W-1];
          if (tick_end) begin
            tick    <= '0;
            shreg   <= order ? (shreg >> 1) : (shreg << 1);
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= S_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_STOP: begin
          tx_out <= STOP_LEVEL;
          if (tick_end) begin
            tick  <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_serial_tx.sv
// Directed bench for led_serial_tx: one BIT_TICKS=4 instance and one
// BIT_TICKS=1 instance sharing clock, reset and data inputs.
module tb_led_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn4;
  logic       btn1;
  logic       lsb_first;
  logic [7:0] data_in;

  logic       tx4, busy4, done4;
  logic [7:0] view4;
  logic       tx1, busy1, done1;
  logic [7:0] view1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       tx_log   [0:255];
  logic       busy_log [0:255];
  logic       done_log [0:255];
  logic [7:0] view_log [0:255];

  always #5 clk = ~clk;

  led_serial_tx #(.DATA_W(8), .BIT_TICKS(4)) dut4 (
    .clk(clk), .reset(reset), .send_button(btn4), .lsb_first(lsb_first),
    .data_in(data_in), .tx_out(tx4), .busy(busy4), .done(done4), .shift_view(view4)
  );

  led_serial_tx #(.DATA_W(8), .BIT_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .send_button(btn1), .lsb_first(lsb_first),
    .data_in(data_in), .tx_out(tx1), .busy(busy1), .done(done1), .shift_view(view1)
  );

  // Line level expected i+1 edges after the raw button rises; bits[7] goes first.
  function automatic logic exp_tx(input int i, input int t, input logic [7:0] bits);
    if (i < 2) return 1'b1;
    if (i < 2 + t) return 1'b0;
    if (i < 2 + 9 * t) return bits[7 - ((i - 2 - t) / t)];
    return 1'b1;
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the button of one instance and log its outputs after each edge.
  task automatic record(input bit sel, input int n, input int hold,
                        input int disturb_at, input int reset_at);
    if (sel) btn1 = 1'b1;
    else     btn4 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == hold) begin
        btn1 = 1'b0;
        btn4 = 1'b0;
      end
      if (disturb_at >= 0 && i == disturb_at) begin
        data_in   = 8'hFF;
        lsb_first = 1'b0;
        btn4      = 1'b1;
      end
      if (disturb_at >= 0 && i == disturb_at + 2) btn4 = 1'b0;
      if (reset_at >= 0 && i == reset_at) reset = 1'b0;
      if (reset_at >= 0 && i == reset_at + 1) reset = 1'b1;
      @(posedge clk);
      #1;
      tx_log[i]   = sel ? tx1 : tx4;
      busy_log[i] = sel ? busy1 : busy4;
      done_log[i] = sel ? done1 : done4;
      view_log[i] = sel ? view1 : view4;
    end
    btn1 = 1'b0;
    btn4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      btn4 = ~btn4;
      btn1 = ~btn1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({tx4, busy4, done4, view4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        tests_failed++;
        $display("FAIL reset4[%0d]: got tx/busy/done/view %b%b%b %h, expected 100 00", c, tx4, busy4, done4, view4);
      end
      tests_run++;
      if ({tx1, busy1, done1, view1} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        tests_failed++;
        $display("FAIL reset1[%0d]: got tx/busy/done/view %b%b%b %h, expected 100 00", c, tx1, busy1, done1, view1);
      end
    end
    btn4 = 1'b0;
    btn1 = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(6);
    tests_run++;
    if ({tx4, busy4, tx1, busy1} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL reset_release: got tx4 busy4 tx1 busy1 %b%b%b%b, expected 1010", tx4, busy4, tx1, busy1);
    end
  endtask

  task automatic test_lsb_frame();
    data_in   = 8'hC1;
    lsb_first = 1'b1;
    record(1'b0, 48, 2, -1, -1);
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 4, 8'b1000_0011)) begin
        tests_failed++;
        $display("FAIL lsb_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 4, 8'b1000_0011));
      end
      tests_run++;
      if (busy_log[i] !== (i >= 1 && i <= 40)) begin
        tests_failed++;
        $display("FAIL lsb_busy[%0d]: got %b, expected %b", i, busy_log[i], (i >= 1 && i <= 40));
      end
      tests_run++;
      if (done_log[i] !== (i == 41)) begin
        tests_failed++;
        $display("FAIL lsb_done[%0d]: got %b, expected %b", i, done_log[i], (i == 41));
      end
    end
    wait_cycles(3);
  endtask

  task automatic test_msb_frame();
    logic [7:0] seq [0:8];
    seq = '{8'hC1, 8'h82, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    data_in   = 8'hC1;
    lsb_first = 1'b0;
    record(1'b0, 48, 2, -1, -1);
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 4, 8'b1100_0001)) begin
        tests_failed++;
        $display("FAIL msb_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 4, 8'b1100_0001));
      end
    end
    tests_run++;
    if (view_log[1] !== seq[0]) begin
      tests_failed++;
      $display("FAIL msb_view_load: got %h, expected %h", view_log[1], seq[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      tests_run++;
      if (view_log[4 + 4 * k] !== seq[k-1]) begin
        tests_failed++;
        $display("FAIL msb_view_hold[%0d]: got %h, expected %h", k, view_log[4 + 4 * k], seq[k-1]);
      end
      tests_run++;
      if (view_log[5 + 4 * k] !== seq[k]) begin
        tests_failed++;
        $display("FAIL msb_view_shift[%0d]: got %h, expected %h", k, view_log[5 + 4 * k], seq[k]);
      end
    end
    wait_cycles(3);
  endtask

  task automatic test_busy_ignore();
    data_in   = 8'hC1;
    lsb_first = 1'b1;
    record(1'b0, 80, 2, 20, -1);
    for (int i = 0; i < 80; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 4, 8'b1000_0011)) begin
        tests_failed++;
        $display("FAIL ignore_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 4, 8'b1000_0011));
      end
      tests_run++;
      if (busy_log[i] !== (i >= 1 && i <= 40)) begin
        tests_failed++;
        $display("FAIL ignore_busy[%0d]: got %b, expected %b", i, busy_log[i], (i >= 1 && i <= 40));
      end
      tests_run++;
      if (done_log[i] !== (i == 41)) begin
        tests_failed++;
        $display("FAIL ignore_done[%0d]: got %b, expected %b", i, done_log[i], (i == 41));
      end
    end
    wait_cycles(3);
  endtask

  task automatic test_reset_mid_frame();
    data_in   = 8'hC1;
    lsb_first = 1'b1;
    record(1'b0, 60, 2, -1, 15);
    tests_run++;
    if ({tx_log[14], view_log[14]} !== {1'b0, 8'h30}) begin
      tests_failed++;
      $display("FAIL abort_before: got tx %b view %h, expected tx 0 view 30", tx_log[14], view_log[14]);
    end
    tests_run++;
    if (view_log[15] !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_view: got %h, expected 00", view_log[15]);
    end
    for (int i = 15; i < 60; i++) begin
      tests_run++;
      if ({tx_log[i], busy_log[i], done_log[i]} !== 3'b100) begin
        tests_failed++;
        $display("FAIL abort_idle[%0d]: got tx/busy/done %b%b%b, expected 100", i, tx_log[i], busy_log[i], done_log[i]);
      end
    end
    wait_cycles(3);
    data_in   = 8'h5A;
    lsb_first = 1'b0;
    record(1'b0, 48, 2, -1, -1);
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 4, 8'b0101_1010)) begin
        tests_failed++;
        $display("FAIL after_reset_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 4, 8'b0101_1010));
      end
      tests_run++;
      if (done_log[i] !== (i == 41)) begin
        tests_failed++;
        $display("FAIL after_reset_done[%0d]: got %b, expected %b", i, done_log[i], (i == 41));
      end
    end
    wait_cycles(3);
  endtask

  task automatic test_held_button_fast();
    data_in   = 8'hC1;
    lsb_first = 1'b1;
    record(1'b1, 110, 100, -1, -1);
    for (int i = 0; i < 110; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 1, 8'b1000_0011)) begin
        tests_failed++;
        $display("FAIL held_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 1, 8'b1000_0011));
      end
      tests_run++;
      if (busy_log[i] !== (i >= 1 && i <= 10)) begin
        tests_failed++;
        $display("FAIL held_busy[%0d]: got %b, expected %b", i, busy_log[i], (i >= 1 && i <= 10));
      end
      tests_run++;
      if (done_log[i] !== (i == 11)) begin
        tests_failed++;
        $display("FAIL held_done[%0d]: got %b, expected %b", i, done_log[i], (i == 11));
      end
    end
    wait_cycles(3);
    data_in   = 8'h5A;
    lsb_first = 1'b0;
    record(1'b1, 20, 2, -1, -1);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (tx_log[i] !== exp_tx(i, 1, 8'b0101_1010)) begin
        tests_failed++;
        $display("FAIL repress_tx[%0d]: got %b, expected %b", i, tx_log[i], exp_tx(i, 1, 8'b0101_1010));
      end
      tests_run++;
      if (done_log[i] !== (i == 11)) begin
        tests_failed++;
        $display("FAIL repress_done[%0d]: got %b, expected %b", i, done_log[i], (i == 11));
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    btn4      = 1'b0;
    btn1      = 1'b0;
    lsb_first = 1'b0;
    data_in   = 8'h00;
    test_reset();
    test_lsb_frame();
    test_msb_frame();
    test_busy_ignore();
    test_reset_mid_frame();
    test_held_button_fast();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
